// File: rtl/bus_arb_pkg.sv
// Shared definitions for the round-robin bus arbiter: FSM state codes and
// small helpers for sizing the owner index and converting one-hot vectors.
package bus_arb_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    // Width needed to index n items, never less than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 <<< i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    // Index of the set bit of a one-hot vector (zero when no bit is set).
    function automatic int onehot_to_idx(input logic [31:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Rotating-priority picker: finds the first requester above ptr, wrapping
// around, so the most recent winner gets the lowest priority.
module rr_pick
    import bus_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic            found,
    output logic [ID_W-1:0] idx,
    output logic [N-1:0]    onehot
);

    logic [ID_W-1:0] k_s;

    // Scan N positions starting one above the pointer; keep only the first hit
    always_comb begin
        onehot = '0;
        found  = 1'b0;
        k_s    = '0;
        for (int i = 1; i <= N; i++) begin
            k_s = ID_W'((int'(ptr) + i) % N);
            if (!found && req[k_s]) begin
                found       = 1'b1;
                onehot[k_s] = 1'b1;
            end else begin
                found = found;
            end
        end
        idx = ID_W'(onehot_to_idx(32'(onehot)));
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for the shared system bus. One owner at a time, owner
// keeps the bus while its request is high, one dead cycle on every handover.
// Optional feature macro: BUS_ARB_TIMEOUT_EN builds a hold counter that
// revokes a grant after MAX_HOLD cycles when another master is waiting;
// without it arb_timeout is constant 0.
module bus_arbiter_rr
    import bus_arb_pkg::*;
#(
    parameter int  N_MASTERS = 4,
    parameter int  MAX_HOLD  = 8,
    localparam int ID_W      = clog2_min1(N_MASTERS)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_MASTERS-1:0] m_req,
    output logic [N_MASTERS-1:0] m_grant,
    output logic [ID_W-1:0]      grant_id,
    output logic                 bus_busy,
    output logic                 arb_timeout
);

    if ((N_MASTERS < 2) || (MAX_HOLD < 2)) begin : g_param_check
        $error("bus_arbiter_rr: N_MASTERS and MAX_HOLD must both be >= 2");
    end

    logic [1:0]           state_q, state_d;
    logic [N_MASTERS-1:0] grant_q, grant_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic                 busy_q, busy_d;

    logic                 pick_found_s;
    logic [ID_W-1:0]      pick_idx_s;
    logic [N_MASTERS-1:0] pick_onehot_s;
    logic                 grant_issue_s;
    logic                 timeout_s;

    rr_pick #(
        .N    (N_MASTERS),
        .ID_W (ID_W)
    ) u_pick (
        .req    (m_req),
        .ptr    (ptr_q),
        .found  (pick_found_s),
        .idx    (pick_idx_s),
        .onehot (pick_onehot_s)
    );

    // A new grant can only be issued from the free or dead-cycle states
    assign grant_issue_s = ((state_q == ST_IDLE) || (state_q == ST_RELEASE)) && pick_found_s;

    // FSM next state: grant, hold, release with one dead cycle
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE, ST_RELEASE: begin
                if (grant_issue_s) begin
                    state_d = ST_GRANT;
                    grant_d = pick_onehot_s;
                    id_d    = pick_idx_s;
                    ptr_d   = pick_idx_s;
                end else begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            end
            ST_GRANT: begin
                if (!m_req[id_q]) begin
                    state_d = ST_RELEASE;
                    grant_d = '0;
                end else if (timeout_s) begin
                    state_d = ST_RELEASE;
                    grant_d = '0;
                end else begin
                    state_d = ST_GRANT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
        busy_d = |grant_d;
    end

    // Arbiter state and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            id_q    <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= ID_W'(N_MASTERS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int HC_W = $clog2(MAX_HOLD + 1);

    logic [HC_W-1:0] hold_q, hold_d;
    logic            to_q, to_d;

    // Preempt only a saturated owner while some other master is waiting
    assign timeout_s = (hold_q == HC_W'(MAX_HOLD)) && ((m_req & ~grant_q) != '0);

    // Hold counter: restart on each grant, count ownership cycles, saturate
    always_comb begin
        if (grant_issue_s) begin
            hold_d = HC_W'(1);
        end else if ((state_q == ST_GRANT) && (hold_q != HC_W'(MAX_HOLD))) begin
            hold_d = hold_q + HC_W'(1);
        end else begin
            hold_d = hold_q;
        end
    end

    // Timeout pulse only when the owner is still requesting (a drop wins)
    always_comb begin
        to_d = (state_q == ST_GRANT) && m_req[id_q] && timeout_s;
    end

    // Hold counter and timeout pulse registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hold_q <= '0;
            to_q   <= 1'b0;
        end else begin
            hold_q <= hold_d;
            to_q   <= to_d;
        end
    end

    assign arb_timeout = to_q;
`else
    assign timeout_s   = 1'b0;
    assign arb_timeout = 1'b0;
`endif

    assign m_grant  = grant_q;
    assign grant_id = id_q;
    assign bus_busy = busy_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr (N_MASTERS=4, MAX_HOLD=8): directed
// scenarios followed by random request traffic, all against a reference model.
module tb_bus_arbiter_rr;

    localparam int N  = 4;
    localparam int MH = 8;
`ifdef BUS_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic [N-1:0] m_req;
    logic [N-1:0] m_grant;
    logic [1:0]   grant_id;
    logic         bus_busy;
    logic         arb_timeout;

    int total = 0;
    int bad   = 0;

    // Reference model: current owner (-1 = none), last winner, hold cycles
    int own;
    int mptr;
    int mhold;
    int exp_id;
    bit exp_to;
    bit id_check;

    bus_arbiter_rr #(.N_MASTERS(N), .MAX_HOLD(MH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .m_req       (m_req),
        .m_grant     (m_grant),
        .grant_id    (grant_id),
        .bus_busy    (bus_busy),
        .arb_timeout (arb_timeout)
    );

    always #5 clk = ~clk;

    task automatic model_edge(input bit rst, input logic [N-1:0] req);
        if (!rst) begin
            own = -1; mptr = N - 1; mhold = 0; exp_to = 1'b0; exp_id = 0; id_check = 1'b1;
        end else begin
            exp_to   = 1'b0;
            id_check = 1'b0;
            if (own >= 0) begin
                if ((req & (4'b0001 << own)) == 4'b0000) begin
                    own = -1;
                end else if (TO_EN && (mhold == MH) && ((req & ~(4'b0001 << own)) != 4'b0000)) begin
                    own = -1;
                    exp_to = 1'b1;
                end else if (mhold < MH) begin
                    mhold++;
                end
            end else if (req != 4'b0000) begin
                for (int i = 1; i <= N; i++) begin
                    int k;
                    k = (mptr + i) % N;
                    if (((req >> k) & 4'b0001) != 4'b0000) begin
                        own = k;
                        break;
                    end
                end
                mptr = own; exp_id = own; mhold = 1;
            end
        end
    endtask

    task automatic check(input string tag);
        logic [N-1:0] eg;
        logic         eb;
        eg = (own >= 0) ? (4'b0001 << own) : 4'b0000;
        eb = (own >= 0);
        total++;
        assert (m_grant === eg) else begin
            bad++; $error("FAIL %s m_grant obs=%b exp=%b", tag, m_grant, eg);
        end
        total++;
        assert (bus_busy === eb) else begin
            bad++; $error("FAIL %s bus_busy obs=%b exp=%b", tag, bus_busy, eb);
        end
        total++;
        assert (arb_timeout === exp_to) else begin
            bad++; $error("FAIL %s arb_timeout obs=%b exp=%b", tag, arb_timeout, exp_to);
        end
        if (eb || id_check) begin
            total++;
            assert (grant_id === 2'(exp_id)) else begin
                bad++; $error("FAIL %s grant_id obs=%0d exp=%0d", tag, grant_id, exp_id);
            end
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, check after it
    task automatic step(input bit rst, input logic [N-1:0] req, input string tag);
        reset_n = rst;
        m_req   = req;
        @(posedge clk);
        model_edge(rst, req);
        #1;
        check(tag);
    endtask

    initial begin
        logic [N-1:0] r;
        logic [N-1:0] prev_g;
        logic [N-1:0] seq[$];
        logic [N-1:0] exp_seq[5];
        int           pulses;

        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        reset_n = 1'b0;
        m_req   = 4'b0000;
        own = -1; mptr = N - 1; mhold = 0; exp_to = 1'b0; exp_id = 0; id_check = 1'b0;

        // 1: reset with all requesting, then first grant to master 0
        step(1'b0, 4'b1111, "t1_rst0");
        step(1'b0, 4'b1111, "t1_rst1");
        step(1'b1, 4'b1111, "t1_first");
        total++;
        assert (m_grant === 4'b0001 && grant_id === 2'd0) else begin
            bad++; $error("FAIL t1_lit m_grant=%b id=%0d exp 0001/0", m_grant, grant_id);
        end

        // 2: single requester 2 for five cycles
        step(1'b0, 4'b0000, "t2_rst");
        for (int c = 0; c < 5; c++) step(1'b1, 4'b0100, "t2_hold");
        step(1'b1, 4'b0000, "t2_drop");
        total++;
        assert (m_grant === 4'b0000 && bus_busy === 1'b0) else begin
            bad++; $error("FAIL t2_lit m_grant=%b busy=%b exp 0000/0", m_grant, bus_busy);
        end

        // 3: all requesting, each owner drops for one cycle after 3 grant cycles
        step(1'b0, 4'b1111, "t3_rst");
        prev_g = 4'b0000;
        for (int c = 0; c < 22; c++) begin
            r = 4'b1111;
            if (own >= 0 && mhold == 3) r = r & ~(4'b0001 << own);
            step(1'b1, r, "t3_rr");
            if (m_grant != 4'b0000 && prev_g == 4'b0000) seq.push_back(m_grant);
            prev_g = m_grant;
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            assert (seq.size() > i && seq[i] === exp_seq[i]) else begin
                bad++; $error("FAIL t3_seq[%0d] obs=%b exp=%b", i, (seq.size() > i) ? seq[i] : 4'bxxxx, exp_seq[i]);
            end
        end

        // 4: two masters held constant (timeout rotates them when enabled)
        step(1'b0, 4'b0000, "t4_rst");
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            step(1'b1, 4'b0011, "t4_hold");
            if (arb_timeout === 1'b1) pulses++;
        end
        total++;
        assert (pulses == (TO_EN ? 4 : 0)) else begin
            bad++; $error("FAIL t4_pulses obs=%0d exp=%0d", pulses, TO_EN ? 4 : 0);
        end

        // 5: lone requester never gets preempted
        step(1'b0, 4'b0000, "t5_rst");
        for (int c = 0; c < 20; c++) step(1'b1, 4'b0001, "t5_lone");

        // 6: reset in the middle of a grant restarts the pointer
        step(1'b0, 4'b0000, "t6_rst");
        step(1'b1, 4'b0100, "t6_g2");
        step(1'b1, 4'b1111, "t6_keep");
        step(1'b0, 4'b1111, "t6_midrst");
        total++;
        assert (m_grant === 4'b0000 && bus_busy === 1'b0 && arb_timeout === 1'b0) else begin
            bad++; $error("FAIL t6_zero m_grant=%b busy=%b to=%b exp all 0", m_grant, bus_busy, arb_timeout);
        end
        step(1'b1, 4'b1111, "t6_after");
        total++;
        assert (m_grant === 4'b0001) else begin
            bad++; $error("FAIL t6_ptr m_grant obs=%b exp=0001", m_grant);
        end

        // 7: random request traffic with occasional resets
        r = 4'b0000;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if ((r & (4'b0001 << i)) != 4'b0000) begin
                    if ($urandom_range(0, 5) == 0) r = r & ~(4'b0001 << i);
                end else begin
                    if ($urandom_range(0, 3) == 0) r = r | (4'b0001 << i);
                end
            end
            step(($urandom_range(0, 79) != 0), r, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
